// File: rtl/imem_debug_ctrl.sv
// ---------------------------------------------------------------------------
// imem_debug_ctrl
//
// Debug-unit sequencer for the fetch stage. It owns the instruction-memory
// write port and the fetch stall/read-enable controls.
//
// A host byte stream is assembled MSB-first into 32-bit words, and each word
// is written to the next word address. After loading, the pipeline either runs
// freely or advances one cycle per step command. Fetch freezes when the
// pipeline reports that it has retired the halt instruction.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | stalled, waiting for 'L' (load), 'C' (continue) or 'S' (step)
// LOAD  | collecting the four bytes of the current word
// WRITE | one-cycle memory write of the assembled word
// CONT  | free run until halt
// STEP  | stalled; each 'S' releases exactly one fetch cycle, 'Q' exits
// DONE  | halted, frozen; only 'L' restarts a load
//
// Ports:
//   i_clk, i_reset     clock and synchronous active-high reset
//   i_rx_data/valid    host byte and its one-cycle strobe
//   i_halt             pipeline halt indication (level or pulse)
//   o_write_en         instruction-memory write strobe
//   o_data, o_addr_wr  write data and word-aligned byte address
//   o_read_en, o_stall fetch read enable and PC/fetch stall
//   o_state            FSM state code
//   o_word_count       words written in the current load
//   o_load_err         sticky overflow flag, cleared by the next 'L'
//
// Every output is a flop. The "output" process computes next values from the
// next state, so no input has a combinational path to any output.
// ---------------------------------------------------------------------------
module imem_debug_ctrl #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int          CNT_W     = 9
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  input  logic             i_halt,
  output logic             o_write_en,
  output logic [31:0]      o_data,
  output logic [31:0]      o_addr_wr,
  output logic             o_read_en,
  output logic             o_stall,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_word_count,
  output logic             o_load_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_CONT  = 3'd3,
    S_STEP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_CONT = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] CMD_QUIT = 8'h51;  // 'Q'

  localparam logic [CNT_W-1:0] WORDS_FULL = CNT_W'(MEM_WORDS);

  state_t           state_q, state_d;
  logic [31:0]      asm_q;
  logic [1:0]       byte_cnt_q;

  logic             stall_d, read_en_d, write_en_d, load_err_d;
  logic [31:0]      data_d, addr_d;
  logic [CNT_W-1:0] word_count_d;

  logic [31:0]      word_next;
  logic             last_byte, overflow, start_load, step_go;

  // The word that results if the current byte is shifted in.
  assign word_next  = {asm_q[23:0], i_rx_data};

  assign last_byte  = (state_q == S_LOAD) && i_rx_valid && (byte_cnt_q == 2'd3);
  assign overflow   = last_byte && (o_word_count == WORDS_FULL);
  assign start_load = i_rx_valid && (i_rx_data == CMD_LOAD) &&
                      ((state_q == S_IDLE) || (state_q == S_DONE));
  // A halt seen together with the step byte wins. The pipeline has already
  // stopped in that case, so no further fetch is released.
  assign step_go    = (state_q == S_STEP) && i_rx_valid &&
                      (i_rx_data == CMD_STEP) && !i_halt;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_rx_valid) begin
          if      (i_rx_data == CMD_LOAD) state_d = S_LOAD;
          else if (i_rx_data == CMD_CONT) state_d = S_CONT;
          else if (i_rx_data == CMD_STEP) state_d = S_STEP;
        end
      end
      S_LOAD: begin
        if (last_byte) state_d = overflow ? S_IDLE : S_WRITE;
      end
      S_WRITE: begin
        // o_data holds the word being written during this cycle.
        state_d = (o_data == HALT_WORD) ? S_IDLE : S_LOAD;
      end
      S_CONT: begin
        if (i_halt) state_d = S_DONE;
      end
      S_STEP: begin
        if (i_halt)                                    state_d = S_DONE;
        else if (i_rx_valid && i_rx_data == CMD_QUIT) state_d = S_IDLE;
      end
      S_DONE: begin
        if (start_load) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    stall_d      = 1'b1;
    read_en_d    = 1'b0;
    write_en_d   = 1'b0;
    data_d       = o_data;
    addr_d       = o_addr_wr;
    word_count_d = o_word_count;
    load_err_d   = o_load_err;

    if (state_d == S_CONT || step_go) begin
      stall_d   = 1'b0;
      read_en_d = 1'b1;
    end

    if (state_d == S_WRITE) begin
      write_en_d = 1'b1;
      data_d     = word_next;
      addr_d     = 32'({o_word_count, 2'b00});
    end

    if (start_load) begin
      word_count_d = '0;
      load_err_d   = 1'b0;
    end else begin
      if (state_q == S_WRITE) word_count_d = o_word_count + 1'b1;
      if (overflow)           load_err_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stall      <= 1'b1;
      o_read_en    <= 1'b0;
      o_write_en   <= 1'b0;
      o_data       <= '0;
      o_addr_wr    <= '0;
      o_word_count <= '0;
      o_load_err   <= 1'b0;
    end else begin
      o_stall      <= stall_d;
      o_read_en    <= read_en_d;
      o_write_en   <= write_en_d;
      o_data       <= data_d;
      o_addr_wr    <= addr_d;
      o_word_count <= word_count_d;
      o_load_err   <= load_err_d;
    end
  end

  // Byte assembly. A byte arriving during WRITE becomes byte 0 of the next
  // word, which keeps a one-byte-per-cycle stream loss-free.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      asm_q      <= '0;
      byte_cnt_q <= '0;
    end else if (start_load) begin
      byte_cnt_q <= '0;
    end else if (i_rx_valid && (state_q == S_LOAD || state_q == S_WRITE)) begin
      asm_q      <= word_next;
      byte_cnt_q <= (state_q == S_WRITE) ? 2'd1 : byte_cnt_q + 2'd1;
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_imem_debug_ctrl.sv
module tb_imem_debug_ctrl;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       rx_data = '0;
  logic             rx_valid = 1'b0;
  logic             halt = 1'b0;
  logic             write_en, read_en, stall, load_err;
  logic [31:0]      data, addr_wr;
  logic [2:0]       state;
  logic [CNT_W-1:0] word_count;

  imem_debug_ctrl #(.MEM_WORDS(4), .HALT_WORD(32'hFFFF_FFFF), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_reset(reset), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_halt(halt), .o_write_en(write_en), .o_data(data), .o_addr_wr(addr_wr),
    .o_read_en(read_en), .o_stall(stall), .o_state(state),
    .o_word_count(word_count), .o_load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_run   = 0;
  logic [63:0] wq[$];

  // Write pulses and released fetch cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (write_en) wq.push_back({addr_wr, data});
    if (!stall)   n_run++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock with the given inputs; outputs settle #1 after the edge.
  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic h);
    reset = r; rx_valid = v; rx_data = d; halt = h;
    @(posedge clk); #1;
    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; halt = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic       h;
    logic [2:0] st;
    logic       stall;
    logic       rd;
    logic       we;
  } vec_t;

  vec_t vt[15];

  logic [31:0] prog_a[12] = '{32'h00, 32'h00, 32'h00, 32'h20, 32'h8C, 32'h01,
                              32'h00, 32'h04, 32'hFF, 32'hFF, 32'hFF, 32'hFF};
  logic [7:0]  prog_b[12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                              8'h77, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    //            rst  v   d      h   st   stl rd  we
    vt[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 8'h43, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 8'h43, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 8'h53, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 8'h4C, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 8'h58, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 8'h53, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 8'h53, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
    vt[13] = '{1'b0, 1'b1, 8'h43, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
    vt[14] = '{1'b0, 1'b1, 8'h51, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};

    // Reset values
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("reset_outputs",
        {state, stall, read_en, write_en, load_err, 3'(word_count), data, addr_wr},
        {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0});

    // Run-control vectors
    for (int i = 0; i < 15; i++) begin
      cyc(vt[i].rst, vt[i].v, vt[i].d, vt[i].h);
      chk($sformatf("vec%0d", i), {state, stall, read_en, write_en},
          {vt[i].st, vt[i].stall, vt[i].rd, vt[i].we});
    end

    // Program load with gaps between bytes
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    wq.delete(); n_run = 0;
    send(8'h4C);
    for (int i = 0; i < 12; i++) begin
      send(prog_a[i][7:0]);
      idle(1);
    end
    idle(2);
    chk("loadA_nwrites", 64'(wq.size()), 64'd3);
    if (wq.size() == 3) begin
      chk("loadA_w0", wq[0], {32'h0, 32'h0000_0020});
      chk("loadA_w1", wq[1], {32'h4, 32'h8C01_0004});
      chk("loadA_w2", wq[2], {32'h8, 32'hFFFF_FFFF});
    end
    chk("loadA_end", {state, 3'(word_count), 1'b0}, {3'd0, 3'd3, 1'b0});
    chk("loadA_stall", 64'(n_run), 64'd0);

    // Back-to-back bytes, one lands on each WRITE cycle
    wq.delete();
    send(8'h4C);
    for (int i = 0; i < 12; i++) send(prog_b[i]);
    idle(2);
    chk("loadB_nwrites", 64'(wq.size()), 64'd3);
    if (wq.size() == 3) begin
      chk("loadB_w0", wq[0], {32'h0, 32'h1122_3344});
      chk("loadB_w1", wq[1], {32'h4, 32'h5566_7788});
      chk("loadB_w2", wq[2], {32'h8, 32'hFFFF_FFFF});
    end
    chk("loadB_end", {state, 3'(word_count)}, {3'd0, 3'd3});

    // Overflow with a 4-word memory
    wq.delete();
    send(8'h4C);
    for (int w = 1; w <= 5; w++) begin
      send(8'h00); send(8'h00); send(8'h00); send(8'(w));
    end
    idle(3);
    chk("ovf_nwrites", 64'(wq.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < wq.size())
        chk($sformatf("ovf_w%0d", i), wq[i], {32'(4 * i), 32'(i + 1)});
    chk("ovf_flags", {state, load_err, 3'(word_count)}, {3'd0, 1'b1, 3'd4});
    idle(2);
    chk("ovf_sticky", 64'(load_err), 64'd1);
    send(8'h4C);
    chk("ovf_clear", {state, load_err, 3'(word_count)}, {3'd1, 1'b0, 3'd0});

    // Three spaced step commands
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    send(8'h53);
    idle(1);
    n_run = 0;
    for (int k = 0; k < 3; k++) begin
      send(8'h53);
      chk($sformatf("step%0d_open", k), {stall, read_en}, {1'b0, 1'b1});
      idle(1);
      chk($sformatf("step%0d_close", k), {stall, read_en}, {1'b1, 1'b0});
      idle(3);
    end
    send(8'h51);
    chk("step_quit", 64'(state), 64'd0);
    chk("step_count", 64'(n_run), 64'd3);

    // Reset in the middle of a word
    wq.delete();
    send(8'h4C);
    send(8'hAB);
    send(8'hCD);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_mid", {state, 3'(word_count), write_en}, {3'd0, 3'd0, 1'b0});
    send(8'h4C);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    idle(2);
    chk("rst_nwrites", 64'(wq.size()), 64'd1);
    if (wq.size() == 1) chk("rst_reload", wq[0], {32'h0, 32'h1234_5678});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
